// File: rtl/iot_event_arbiter_if.sv
// Request/event bundle between IoT device ports and the active-device monitor.
// IOT_ARB_STATS_EN adds the drop_cnt statistics output.
interface iot_event_arbiter_if #(
  parameter int N_DEV = 8
);
  logic [N_DEV-1:0] dev_join;
  logic [N_DEV-1:0] dev_leave;
  logic             change;
  logic             on_off;
  logic [N_DEV-1:0] dev_active;
  logic             pending;
`ifdef IOT_ARB_STATS_EN
  logic [7:0]       drop_cnt;

  modport slave  (input  dev_join, dev_leave,
                  output change, on_off, dev_active, pending, drop_cnt);
  modport master (output dev_join, dev_leave,
                  input  change, on_off, dev_active, pending, drop_cnt);
`else
  modport slave  (input  dev_join, dev_leave,
                  output change, on_off, dev_active, pending);
  modport master (output dev_join, dev_leave,
                  input  change, on_off, dev_active, pending);
`endif
endinterface

// File: rtl/iot_event_arbiter.sv
// Serialises per-device join/leave pulses into one up/down event per cycle.
// Optional IOT_ARB_STATS_EN: saturating count of redundant/cancelled requests.
module iot_event_arbiter #(
  parameter int N_DEV = 8,
  parameter int PTR_W = 3
) (
  input logic               clk,
  input logic               rst,
  iot_event_arbiter_if.slave bus
);

  logic [N_DEV-1:0] pend_v_q, pend_v_d;
  logic [N_DEV-1:0] pend_d_q, pend_d_d;
  logic [N_DEV-1:0] active_q, active_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             change_q, change_d;
  logic             on_off_q, on_off_d;
  logic             pending_q, pending_d;
  logic [N_DEV-1:0] eff;
  logic             grant_v;
  int               grant_idx;

  // Round-robin search from the pointer, then fold captured requests on top of the grant.
  // Requests always see the pre-grant effective state; a cancel on the device being
  // granted this cycle therefore turns into a freshly queued opposite event.
  always_comb begin
    eff       = active_q ^ pend_v_q;
    grant_v   = 1'b0;
    grant_idx = 0;
    for (int k = 0; k < N_DEV; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % N_DEV;
      if (!grant_v && pend_v_q[idx]) begin
        grant_v   = 1'b1;
        grant_idx = idx;
      end
    end

    pend_v_d = pend_v_q;
    pend_d_d = pend_d_q;
    active_d = active_q;
    ptr_d    = ptr_q;
    change_d = grant_v;
    on_off_d = on_off_q;
    if (grant_v) begin
      active_d[grant_idx] = ~active_q[grant_idx];
      pend_v_d[grant_idx] = 1'b0;
      on_off_d            = pend_d_q[grant_idx];
      ptr_d               = PTR_W'((grant_idx + 1) % N_DEV);
    end

    for (int i = 0; i < N_DEV; i++) begin
      if (bus.dev_join[i] ^ bus.dev_leave[i]) begin
        if (bus.dev_join[i] != eff[i]) begin
          if (!pend_v_q[i] || (grant_v && grant_idx == i)) begin
            pend_v_d[i] = 1'b1;
            pend_d_d[i] = bus.dev_join[i];
          end else begin
            pend_v_d[i] = 1'b0;
          end
        end
      end
    end
    pending_d = |pend_v_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend_v_q  <= '0;
      pend_d_q  <= '0;
      active_q  <= '0;
      ptr_q     <= '0;
      change_q  <= 1'b0;
      on_off_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      pend_v_q  <= pend_v_d;
      pend_d_q  <= pend_d_d;
      active_q  <= active_d;
      ptr_q     <= ptr_d;
      change_q  <= change_d;
      on_off_q  <= on_off_d;
      pending_q <= pending_d;
    end
  end

  assign bus.change     = change_q;
  assign bus.on_off     = on_off_q;
  assign bus.dev_active = active_q;
  assign bus.pending    = pending_q;

`ifdef IOT_ARB_STATS_EN
  logic [N_DEV-1:0] drop_mask;
  logic [7:0]       drop_q, drop_d;

  // A request is dropped when contradictory, redundant, or cancelling a queued event.
  always_comb begin
    drop_mask = '0;
    for (int i = 0; i < N_DEV; i++) begin
      drop_mask[i] = (bus.dev_join[i] & bus.dev_leave[i]) |
                     ((bus.dev_join[i] ^ bus.dev_leave[i]) &
                      ((bus.dev_join[i] == eff[i]) |
                       (pend_v_q[i] & ~(grant_v && grant_idx == i))));
    end
    if (int'(drop_q) + $countones(drop_mask) > 255) begin
      drop_d = 8'hFF;
    end else begin
      drop_d = drop_q + 8'($countones(drop_mask));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign bus.drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_iot_event_arbiter.sv
// Directed, table-driven bench for iot_event_arbiter (drop_cnt checked when
// IOT_ARB_STATS_EN is defined).
module tb_iot_event_arbiter;

  typedef struct {
    logic       rst_n;
    logic [7:0] join_v;
    logic [7:0] leave_v;
    logic       change;
    logic       on_off;
    logic [7:0] active;
    logic       pending;
    logic [7:0] drop;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs [31];

  iot_event_arbiter_if #(.N_DEV(8)) bus ();

  iot_event_arbiter #(.N_DEV(8), .PTR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rst_n, input logic [7:0] j, input logic [7:0] l);
    @(negedge clk);
    rst           = rst_n;
    bus.dev_join  = j;
    bus.dev_leave = l;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic c, input logic o,
                             input logic [7:0] a, input logic p, input logic [7:0] d);
    checks++;
    if (bus.change !== c) begin
      errors++;
      $display("[TB] FAIL %s change: got %0b want %0b", name, bus.change, c);
    end
    checks++;
    if (bus.on_off !== o) begin
      errors++;
      $display("[TB] FAIL %s on_off: got %0b want %0b", name, bus.on_off, o);
    end
    checks++;
    if (bus.dev_active !== a) begin
      errors++;
      $display("[TB] FAIL %s dev_active: got %h want %h", name, bus.dev_active, a);
    end
    checks++;
    if (bus.pending !== p) begin
      errors++;
      $display("[TB] FAIL %s pending: got %0b want %0b", name, bus.pending, p);
    end
`ifdef IOT_ARB_STATS_EN
    checks++;
    if (bus.drop_cnt !== d) begin
      errors++;
      $display("[TB] FAIL %s drop_cnt: got %0d want %0d", name, bus.drop_cnt, d);
    end
`else
    if (d != d) errors++;
`endif
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    bus.dev_join  = '0;
    bus.dev_leave = '0;

    // single join, then a redundant repeat
    vecs[0]  = '{1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'd0};
    vecs[1]  = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 8'h01, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 8'd1};
    vecs[3]  = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0, 8'd1};
    // reset, then all devices join at once: eight back-to-back grants 0..7
    vecs[4]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0};
    vecs[5]  = '{1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'd0};
    vecs[6]  = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'h01, 1'b1, 8'd0};
    vecs[7]  = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'h03, 1'b1, 8'd0};
    vecs[8]  = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'h07, 1'b1, 8'd0};
    vecs[9]  = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'h0F, 1'b1, 8'd0};
    vecs[10] = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'h1F, 1'b1, 8'd0};
    vecs[11] = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'h3F, 1'b1, 8'd0};
    vecs[12] = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'h7F, 1'b1, 8'd0};
    vecs[13] = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 8'd0};
    vecs[14] = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0, 8'd0};
    // leave 0,1,3 queued; join(3) cancels before device 3 is reached
    vecs[15] = '{1'b1, 8'h00, 8'h0B, 1'b0, 1'b1, 8'hFF, 1'b1, 8'd0};
    vecs[16] = '{1'b1, 8'h08, 8'h00, 1'b1, 1'b0, 8'hFE, 1'b1, 8'd1};
    vecs[17] = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFC, 1'b0, 8'd1};
    vecs[18] = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'hFC, 1'b0, 8'd1};
    // contradictory request and leave of an inactive device
    vecs[19] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0};
    vecs[20] = '{1'b1, 8'h04, 8'h04, 1'b0, 1'b0, 8'h00, 1'b0, 8'd1};
    vecs[21] = '{1'b1, 8'h00, 8'h20, 1'b0, 1'b0, 8'h00, 1'b0, 8'd2};
    // move pointer to 6, then 1 and 7 queued: wrap grants 7 then 1
    vecs[22] = '{1'b1, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'd2};
    vecs[23] = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 1'b0, 8'd2};
    vecs[24] = '{1'b1, 8'h82, 8'h00, 1'b0, 1'b1, 8'h20, 1'b1, 8'd2};
    vecs[25] = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'hA0, 1'b1, 8'd2};
    vecs[26] = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'hA2, 1'b0, 8'd2};
    // reset in the middle of a queue flushes it
    vecs[27] = '{1'b1, 8'h1C, 8'h00, 1'b0, 1'b1, 8'hA2, 1'b1, 8'd2};
    vecs[28] = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'hA6, 1'b1, 8'd2};
    vecs[29] = '{1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0};
    vecs[30] = '{1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'd0};

    // reset held with random requests
    for (int r = 0; r < 2; r++) begin
      applyStimulus(1'b0, 8'($urandom), 8'($urandom));
      checkOutput($sformatf("reset%0d", r), 1'b0, 1'b0, 8'h00, 1'b0, 8'd0);
    end

    for (int v = 0; v < 31; v++) begin
      applyStimulus(vecs[v].rst_n, vecs[v].join_v, vecs[v].leave_v);
      checkOutput($sformatf("vec%0d", v), vecs[v].change, vecs[v].on_off,
                  vecs[v].active, vecs[v].pending, vecs[v].drop);
    end

    // requests on the device being granted in the same cycle
    applyStimulus(1'b1, 8'h01, 8'h00);
    checkOutput("sameA", 1'b0, 1'b0, 8'h00, 1'b1, 8'd0);
    applyStimulus(1'b1, 8'h00, 8'h01);
    checkOutput("sameB", 1'b1, 1'b1, 8'h01, 1'b1, 8'd0);
    applyStimulus(1'b1, 8'h01, 8'h00);
    checkOutput("sameC", 1'b1, 1'b0, 8'h00, 1'b1, 8'd0);
    applyStimulus(1'b1, 8'h01, 8'h00);
    checkOutput("sameD", 1'b1, 1'b1, 8'h01, 1'b0, 8'd1);
    applyStimulus(1'b1, 8'h00, 8'h00);
    checkOutput("sameE", 1'b0, 1'b1, 8'h01, 1'b0, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
